divu_hilo_unit: RTL and testbench



---
 rtl/divu_hilo_unit.sv | 131 +++++++++++++
 tb/tb_divu_hilo_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/divu_hilo_unit.sv
// Sequential unsigned restoring divider (one quotient bit per cycle) feeding
// an architectural HI/LO pair that is written only on an explicit commit code.
module divu_hilo_unit #(
    parameter int         WIDTH       = 32,
    parameter int         ITER_W      = 6,
    parameter logic [5:0] DIVU_CODE   = 6'b011011,
    parameter logic [5:0] COMMIT_CODE = 6'b111111,
    parameter logic [5:0] MFHI_CODE   = 6'b010000,
    parameter logic [5:0] MFLO_CODE   = 6'b010010
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       signal,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(WIDTH);

    logic [1:0]        state_q, state_d;
    logic [WIDTH-1:0]  r_q, r_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [ITER_W-1:0] count_q, count_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic              dbz_q, dbz_d;

    // Partial remainder kept one bit wider so divisors above 2^(WIDTH-1) work.
    logic [WIDTH:0]    trial;
    logic [WIDTH:0]    b_ext;

    assign trial = {r_q, q_q[WIDTH-1]};
    assign b_ext = {1'b0, b_q};

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        b_d     = b_q;
        count_d = count_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dbz_d   = dbz_q;

        case (state_q)
            ST_IDLE: begin
                if (signal == DIVU_CODE) begin
                    q_d     = dividend;
                    b_d     = divisor;
                    r_d     = '0;
                    count_d = '0;
                    dbz_d   = (divisor == '0);
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (signal == DIVU_CODE) begin
                    if (trial >= b_ext) begin
                        r_d = WIDTH'(trial - b_ext);
                        q_d = {q_q[WIDTH-2:0], 1'b1};
                    end else begin
                        r_d = trial[WIDTH-1:0];
                        q_d = {q_q[WIDTH-2:0], 1'b0};
                    end
                    count_d = count_q + 1'b1;
                    if (count_d == LAST_ITER) begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (signal == COMMIT_CODE) begin
                    hi_d    = r_q;
                    lo_d    = q_q;
                    state_d = ST_IDLE;
                end else if (signal != DIVU_CODE) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            r_q     <= '0;
            q_q     <= '0;
            b_q     <= '0;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            b_q     <= b_d;
            count_q <= count_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dbz_q   <= dbz_d;
        end
    end

    // Reads only ever expose committed HI/LO, never the in-flight R/Q.
    always_comb begin
        result = '0;
        if (signal == MFHI_CODE) begin
            result = hi_q;
        end else if (signal == MFLO_CODE) begin
            result = lo_q;
        end
    end

    assign busy        = (state_q == ST_RUN);
    assign done        = (state_q == ST_DONE);
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divu_hilo_unit.sv
// Directed bench for divu_hilo_unit: a table of full divisions plus hand-written
// abort, premature-commit and reset sequences.
module tb_divu_hilo_unit;

    localparam logic [5:0] DIVU   = 6'b011011;
    localparam logic [5:0] COMMIT = 6'b111111;
    localparam logic [5:0] MFHI   = 6'b010000;
    localparam logic [5:0] MFLO   = 6'b010010;
    localparam logic [5:0] ADD    = 6'b100000;

    logic        clk;
    logic        rst_n;
    logic [5:0]  signal;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] result;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] dvd;
        logic [31:0] dvs;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dbz;
    } vec_t;

    vec_t vecs[7];

    divu_hilo_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .signal      (signal),
        .dividend    (dividend),
        .divisor     (divisor),
        .result      (result),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        logic [5:0] saved;
        saved  = signal;
        signal = MFHI;
        #1;
        check({tag, "_hi"}, result, exp_hi);
        signal = MFLO;
        #1;
        check({tag, "_lo"}, result, exp_lo);
        signal = saved;
        #1;
    endtask

    // Start edge, 32 iteration edges, then one commit edge.
    task automatic run_div(input vec_t v, input int idx);
        signal   = DIVU;
        dividend = v.dvd;
        divisor  = v.dvs;
        step();
        check($sformatf("v%0d_busy_start", idx), {31'b0, busy}, 32'd1);
        check($sformatf("v%0d_dbz", idx), {31'b0, div_by_zero}, {31'b0, v.dbz});
        dividend = 32'hDEAD_BEEF;
        divisor  = 32'h0000_0001;
        repeat (31) step();
        check($sformatf("v%0d_busy_e32", idx), {31'b0, busy}, 32'd1);
        step();
        check($sformatf("v%0d_done_e33", idx), {30'b0, busy, done}, 32'd1);
        signal = COMMIT;
        step();
        check($sformatf("v%0d_idle_after_commit", idx), {30'b0, busy, done}, 32'd0);
        check_hilo($sformatf("v%0d", idx), v.hi, v.lo);
        $display("div %h / %h : expect lo=%h hi=%h dbz=%0d", v.dvd, v.dvs, v.lo, v.hi, v.dbz);
    endtask

    initial begin
        vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
        vecs[1] = '{32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  1'b1};
        vecs[2] = '{32'd10,         32'd3,          32'd3,          32'd1,          1'b0};
        vecs[3] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0};
        vecs[4] = '{32'd5,          32'hFFFF_FFFF,  32'd0,          32'd5,          1'b0};
        vecs[5] = '{32'd0,          32'd9,          32'd0,          32'd0,          1'b0};
        vecs[6] = '{32'hFFFF_FFFF,  32'h8000_0001,  32'd1,          32'h7FFF_FFFE,  1'b0};

        rst_n    = 1'b0;
        signal   = 6'd0;
        dividend = '0;
        divisor  = '0;
        step();
        step();
        check("reset_flags", {29'b0, busy, done, div_by_zero}, 32'd0);
        check_hilo("reset", 32'd0, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_div(vecs[i], i);
        end

        // Preload HI/LO with 100/7, then abort a 50/3 at edge 10.
        run_div(vecs[0], 0);
        signal   = DIVU;
        dividend = 32'd50;
        divisor  = 32'd3;
        repeat (9) step();
        check("abort_busy_before", {31'b0, busy}, 32'd1);
        signal = ADD;
        step();
        check("abort_flags", {30'b0, busy, done}, 32'd0);
        check_hilo("abort", 32'd2, 32'd14);
        $display("abort 50/3 at edge 10");

        // Commit in IDLE and commit mid-RUN both leave HI/LO alone.
        signal = COMMIT;
        step();
        check("idle_commit_flags", {30'b0, busy, done}, 32'd0);
        check_hilo("idle_commit", 32'd2, 32'd14);
        signal   = DIVU;
        dividend = 32'd50;
        divisor  = 32'd3;
        repeat (19) step();
        signal = COMMIT;
        step();
        check("run_commit_flags", {30'b0, busy, done}, 32'd0);
        check_hilo("run_commit", 32'd2, 32'd14);
        $display("premature commits in IDLE and at RUN edge 20");

        // Reset at edge 15 of RUN.
        signal = DIVU;
        repeat (14) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rst_run_flags", {30'b0, busy, done}, 32'd0);
        check_hilo("rst_run", 32'd0, 32'd0);
        $display("reset at RUN edge 15");

        // Reach DONE, hold DIVU one extra edge, then reset.
        run_div(vecs[0], 0);
        signal   = DIVU;
        dividend = 32'd77;
        divisor  = 32'd5;
        repeat (33) step();
        check("done_reached", {30'b0, busy, done}, 32'd1);
        step();
        check("done_hold", {30'b0, busy, done}, 32'd1);
        check_hilo("done_hold", 32'd2, 32'd14);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rst_done_flags", {29'b0, busy, done, div_by_zero}, 32'd0);
        check_hilo("rst_done", 32'd0, 32'd0);
        $display("reset in DONE");

        run_div('{32'd9, 32'd2, 32'd4, 32'd1, 1'b0}, 9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
